// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: per-register pending-write counters, predicate counters and
// per-unit occupancy, producing a combinational stall/issue decision with zero latency.
module issue_scoreboard #(
  parameter int unsigned REG_BITS       = 4,
  parameter int unsigned PRED_REG_BITS  = 2,
  parameter int unsigned FUNC_UNIT_BITS = 3,
  parameter int unsigned CNT_BITS       = 2,
  parameter int unsigned WB_PORTS       = 2,
  parameter int unsigned UNIT_DEPTH     = 2,
  parameter logic [(2**FUNC_UNIT_BITS)-1:0] TRACKED_UNITS = 8'b0001_1010,
  parameter int unsigned ALLOW_WAW      = 0,
  parameter int unsigned WB_BYPASS      = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              issue_valid,
  input  logic [PRED_REG_BITS-1:0]          pred_reg_addr,
  input  logic                              pred_reg_valid,
  input  logic [REG_BITS-1:0]               dest_reg_addr,
  input  logic                              dest_reg_valid,
  input  logic [REG_BITS-1:0]               reg_src1_addr,
  input  logic                              reg_src1_valid,
  input  logic [REG_BITS-1:0]               reg_src2_addr,
  input  logic                              reg_src2_valid,
  input  logic [PRED_REG_BITS-1:0]          dest_pred_addr,
  input  logic                              dest_pred_valid,
  input  logic [PRED_REG_BITS-1:0]          pred_src1_addr,
  input  logic                              pred_src1_valid,
  input  logic [PRED_REG_BITS-1:0]          pred_src2_addr,
  input  logic                              pred_src2_valid,
  input  logic [FUNC_UNIT_BITS-1:0]         func_unit,
  input  logic [WB_PORTS-1:0]               wr_reg,
  input  logic [WB_PORTS*REG_BITS-1:0]      wr_reg_addr,
  input  logic [WB_PORTS-1:0]               wr_pred,
  input  logic [WB_PORTS*PRED_REG_BITS-1:0] wr_pred_addr,
  input  logic [(2**FUNC_UNIT_BITS)-1:0]    free_unit,
  output logic                              stall,
  output logic                              issue_fire,
  output logic                              idle,
  output logic                              sb_error
);

  localparam int NREG  = 1 << REG_BITS;
  localparam int NPRED = 1 << PRED_REG_BITS;
  localparam int NFU   = 1 << FUNC_UNIT_BITS;
  localparam int CMAX  = (1 << CNT_BITS) - 1;

  logic [CNT_BITS-1:0] reg_cnt_q  [NREG];
  logic [CNT_BITS-1:0] reg_cnt_d  [NREG];
  logic [CNT_BITS-1:0] pred_cnt_q [NPRED];
  logic [CNT_BITS-1:0] pred_cnt_d [NPRED];
  logic [3:0]          unit_occ_q [NFU];
  logic [3:0]          unit_occ_d [NFU];

  int reg_dec  [NREG];
  int reg_eff  [NREG];
  int pred_dec [NPRED];
  int pred_eff [NPRED];

  logic idle_q, idle_d;
  logic err_q, err_evt;
  logic src_hazard, waw_hazard, unit_busy;

  // Count still outstanding once this cycle's writebacks are credited.
  function automatic int eff_count(input int cnt, input int dec);
    if (WB_BYPASS == 0) return cnt;
    return (dec >= cnt) ? 0 : cnt - dec;
  endfunction

  function automatic logic waw_block(input int cnt);
    return (ALLOW_WAW != 0) ? (cnt == CMAX) : (cnt != 0);
  endfunction

  // Decrements beyond the current count are dropped; an increment past lim is dropped.
  function automatic int count_next(input int cnt, input logic inc, input int dec,
                                    input int lim, output logic err);
    int taken;
    int res;
    err   = 1'b0;
    taken = dec;
    if (dec > cnt) begin
      taken = cnt;
      err   = 1'b1;
    end
    res = cnt - taken;
    if (inc) begin
      if (res + 1 > lim) err = 1'b1;
      else               res = res + 1;
    end
    return res;
  endfunction

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      reg_dec[r] = 0;
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wr_reg[k] && (wr_reg_addr[k*REG_BITS +: REG_BITS] == REG_BITS'(r))) begin
          reg_dec[r] = reg_dec[r] + 1;
        end
      end
      reg_eff[r] = eff_count(int'(reg_cnt_q[r]), reg_dec[r]);
    end
    for (int p = 0; p < NPRED; p++) begin
      pred_dec[p] = 0;
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wr_pred[k] && (wr_pred_addr[k*PRED_REG_BITS +: PRED_REG_BITS] == PRED_REG_BITS'(p)))
        begin
          pred_dec[p] = pred_dec[p] + 1;
        end
      end
      pred_eff[p] = eff_count(int'(pred_cnt_q[p]), pred_dec[p]);
    end
  end

  always_comb begin
    src_hazard = (reg_src1_valid  && (reg_eff[reg_src1_addr]   != 0)) ||
                 (reg_src2_valid  && (reg_eff[reg_src2_addr]   != 0)) ||
                 (pred_reg_valid  && (pred_eff[pred_reg_addr]  != 0)) ||
                 (pred_src1_valid && (pred_eff[pred_src1_addr] != 0)) ||
                 (pred_src2_valid && (pred_eff[pred_src2_addr] != 0));
    waw_hazard = (dest_reg_valid  && waw_block(int'(reg_cnt_q[dest_reg_addr]))) ||
                 (dest_pred_valid && waw_block(int'(pred_cnt_q[dest_pred_addr])));
    // A free pulse in the same cycle is not credited to the issuing instruction.
    unit_busy  = TRACKED_UNITS[func_unit] &&
                 (int'(unit_occ_q[func_unit]) == int'(UNIT_DEPTH));
    stall      = issue_valid && (src_hazard || waw_hazard || unit_busy);
    issue_fire = issue_valid && !stall;
  end

  always_comb begin
    int   nxt;
    logic e;
    nxt     = 0;
    e       = 1'b0;
    err_evt = 1'b0;
    idle_d  = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      nxt = count_next(int'(reg_cnt_q[r]),
                       issue_fire && dest_reg_valid && (dest_reg_addr == REG_BITS'(r)),
                       reg_dec[r], CMAX, e);
      reg_cnt_d[r] = CNT_BITS'(nxt);
      err_evt      = err_evt | e;
      idle_d       = idle_d & (nxt == 0);
    end
    for (int p = 0; p < NPRED; p++) begin
      nxt = count_next(int'(pred_cnt_q[p]),
                       issue_fire && dest_pred_valid && (dest_pred_addr == PRED_REG_BITS'(p)),
                       pred_dec[p], CMAX, e);
      pred_cnt_d[p] = CNT_BITS'(nxt);
      err_evt       = err_evt | e;
      idle_d        = idle_d & (nxt == 0);
    end
    for (int u = 0; u < NFU; u++) begin
      if (TRACKED_UNITS[u]) begin
        nxt = count_next(int'(unit_occ_q[u]),
                         issue_fire && (func_unit == FUNC_UNIT_BITS'(u)),
                         free_unit[u] ? 1 : 0, int'(UNIT_DEPTH), e);
      end else begin
        nxt = 0;
        e   = 1'b0;
      end
      unit_occ_d[u] = 4'(nxt);
      err_evt       = err_evt | e;
      idle_d        = idle_d & (nxt == 0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++)  reg_cnt_q[r]  <= '0;
      for (int p = 0; p < NPRED; p++) pred_cnt_q[p] <= '0;
      for (int u = 0; u < NFU; u++)   unit_occ_q[u] <= '0;
      idle_q <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++)  reg_cnt_q[r]  <= reg_cnt_d[r];
      for (int p = 0; p < NPRED; p++) pred_cnt_q[p] <= pred_cnt_d[p];
      for (int u = 0; u < NFU; u++)   unit_occ_q[u] <= unit_occ_d[u];
      idle_q <= idle_d;
      err_q  <= err_q | err_evt;
    end
  end

  assign idle     = idle_q;
  assign sb_error = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a vector table for the default build plus
// hand sequences for WAW saturation, underflow, predicates and mid-stream reset.
module tb_issue_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [1:0] pred_reg_addr;
  logic       pred_reg_valid;
  logic [3:0] dest_reg_addr;
  logic       dest_reg_valid;
  logic [3:0] reg_src1_addr;
  logic       reg_src1_valid;
  logic [3:0] reg_src2_addr;
  logic       reg_src2_valid;
  logic [1:0] dest_pred_addr;
  logic       dest_pred_valid;
  logic [1:0] pred_src1_addr;
  logic       pred_src1_valid;
  logic [1:0] pred_src2_addr;
  logic       pred_src2_valid;
  logic [2:0] func_unit;
  logic [1:0] wr_reg;
  logic [7:0] wr_reg_addr;
  logic [1:0] wr_pred;
  logic [3:0] wr_pred_addr;
  logic [7:0] free_unit;
  logic       stall, issue_fire, idle, sb_error;
  logic       w_stall, w_fire, w_idle, w_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .pred_reg_addr(pred_reg_addr), .pred_reg_valid(pred_reg_valid),
    .dest_reg_addr(dest_reg_addr), .dest_reg_valid(dest_reg_valid),
    .reg_src1_addr(reg_src1_addr), .reg_src1_valid(reg_src1_valid),
    .reg_src2_addr(reg_src2_addr), .reg_src2_valid(reg_src2_valid),
    .dest_pred_addr(dest_pred_addr), .dest_pred_valid(dest_pred_valid),
    .pred_src1_addr(pred_src1_addr), .pred_src1_valid(pred_src1_valid),
    .pred_src2_addr(pred_src2_addr), .pred_src2_valid(pred_src2_valid),
    .func_unit(func_unit), .wr_reg(wr_reg), .wr_reg_addr(wr_reg_addr),
    .wr_pred(wr_pred), .wr_pred_addr(wr_pred_addr), .free_unit(free_unit),
    .stall(stall), .issue_fire(issue_fire), .idle(idle), .sb_error(sb_error)
  );

  issue_scoreboard #(.ALLOW_WAW(1)) dut_waw (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .pred_reg_addr(pred_reg_addr), .pred_reg_valid(pred_reg_valid),
    .dest_reg_addr(dest_reg_addr), .dest_reg_valid(dest_reg_valid),
    .reg_src1_addr(reg_src1_addr), .reg_src1_valid(reg_src1_valid),
    .reg_src2_addr(reg_src2_addr), .reg_src2_valid(reg_src2_valid),
    .dest_pred_addr(dest_pred_addr), .dest_pred_valid(dest_pred_valid),
    .pred_src1_addr(pred_src1_addr), .pred_src1_valid(pred_src1_valid),
    .pred_src2_addr(pred_src2_addr), .pred_src2_valid(pred_src2_valid),
    .func_unit(func_unit), .wr_reg(wr_reg), .wr_reg_addr(wr_reg_addr),
    .wr_pred(wr_pred), .wr_pred_addr(wr_pred_addr), .free_unit(free_unit),
    .stall(w_stall), .issue_fire(w_fire), .idle(w_idle), .sb_error(w_err)
  );

  typedef struct {
    logic       iv, dv;
    logic [3:0] da;
    logic       s1v;
    logic [3:0] s1a;
    logic       s2v;
    logic [3:0] s2a;
    logic [2:0] fu;
    logic [1:0] wr;
    logic [3:0] wa0, wa1;
    logic [7:0] fr;
    logic       st, fi, id, er;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int iv, input int dv, input int da, input int s1v, input int s1a,
                     input int s2v, input int s2a, input int fu, input int wr, input int wa0,
                     input int wa1, input int fr, input int st, input int fi, input int id,
                     input int er);
    vec_t v;
    v.iv = iv[0];   v.dv = dv[0];   v.da = da[3:0];
    v.s1v = s1v[0]; v.s1a = s1a[3:0];
    v.s2v = s2v[0]; v.s2a = s2a[3:0];
    v.fu = fu[2:0]; v.wr = wr[1:0]; v.wa0 = wa0[3:0]; v.wa1 = wa1[3:0]; v.fr = fr[7:0];
    v.st = st[0];   v.fi = fi[0];   v.id = id[0];     v.er = er[0];
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    issue_valid = 0; pred_reg_addr = 0; pred_reg_valid = 0;
    dest_reg_addr = 0; dest_reg_valid = 0; reg_src1_addr = 0; reg_src1_valid = 0;
    reg_src2_addr = 0; reg_src2_valid = 0; dest_pred_addr = 0; dest_pred_valid = 0;
    pred_src1_addr = 0; pred_src1_valid = 0; pred_src2_addr = 0; pred_src2_valid = 0;
    func_unit = 0; wr_reg = 0; wr_reg_addr = 0; wr_pred = 0; wr_pred_addr = 0;
    free_unit = 0;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    #1;
    check("reset idle", idle, 1'b1);
    check("reset sb_error", sb_error, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic issue_dest(input int r);
    clear_inputs();
    issue_valid = 1; dest_reg_valid = 1; dest_reg_addr = r[3:0];
  endtask

  initial begin
    // iv dv da s1v s1a s2v s2a fu wr wa0 wa1 fr   st fi id er
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0);
    add(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 0);
    add(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
    add(1, 0, 0, 1, 5, 0, 0, 0, 1, 5, 0, 8'h00, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0);
    add(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
    add(1, 1, 2, 0, 0, 0, 0, 0, 2, 0, 2, 8'h00, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 8'h00, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 8'h00, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 8'h00, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 8'h08, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 8'h00, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 8'h00, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 8'h00, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h08, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h08, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0);
    add(1, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 1, 1, 0);
    add(1, 1, 10, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 1, 0, 0);
    add(1, 0, 0, 1, 9, 1, 10, 4, 3, 9, 10, 8'h00, 0, 1, 0, 0);
    add(1, 0, 0, 1, 9, 0, 0, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h12, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h02, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0);

    @(negedge clk);
    do_reset();
    foreach (vecs[i]) begin
      clear_inputs();
      issue_valid = vecs[i].iv; dest_reg_valid = vecs[i].dv; dest_reg_addr = vecs[i].da;
      reg_src1_valid = vecs[i].s1v; reg_src1_addr = vecs[i].s1a;
      reg_src2_valid = vecs[i].s2v; reg_src2_addr = vecs[i].s2a;
      func_unit = vecs[i].fu; wr_reg = vecs[i].wr;
      wr_reg_addr = {vecs[i].wa1, vecs[i].wa0}; free_unit = vecs[i].fr;
      #1;
      check($sformatf("v%0d stall", i), stall, vecs[i].st);
      check($sformatf("v%0d issue_fire", i), issue_fire, vecs[i].fi);
      check($sformatf("v%0d idle", i), idle, vecs[i].id);
      check($sformatf("v%0d sb_error", i), sb_error, vecs[i].er);
      @(negedge clk);
    end

    // WAW saturation with ALLOW_WAW=1: three pending writes to r3 fill the counter.
    do_reset();
    for (int n = 0; n < 7; n++) begin
      issue_dest(3);
      if (n == 4) begin
        wr_reg = 2'b01; wr_reg_addr = 8'h03;
      end
      #1;
      check($sformatf("waw%0d stall", n), w_stall, (n == 3 || n == 4 || n == 6));
      check($sformatf("waw%0d fire", n), w_fire, !(n == 3 || n == 4 || n == 6));
      @(negedge clk);
    end
    clear_inputs();
    #1;
    check("waw sb_error", w_err, 1'b0);
    check("waw idle", w_idle, 1'b0);

    // Double writeback on a count of 1 alongside an increment: one decrement dropped.
    do_reset();
    issue_dest(7);
    @(negedge clk);
    issue_dest(7);
    wr_reg = 2'b11; wr_reg_addr = {4'd7, 4'd7};
    #1;
    check("uf fire", w_fire, 1'b1);
    check("uf err before edge", w_err, 1'b0);
    @(negedge clk);
    clear_inputs();
    issue_valid = 1; reg_src1_valid = 1; reg_src1_addr = 4'd7;
    #1;
    check("uf r7 pending", w_stall, 1'b1);
    check("uf sb_error", w_err, 1'b1);
    wr_reg = 2'b01; wr_reg_addr = 8'h07;
    #1;
    check("uf r7 count one", w_stall, 1'b0);
    @(negedge clk);
    clear_inputs();
    #1;
    check("uf idle", w_idle, 1'b1);
    check("uf sticky", w_err, 1'b1);

    // Predicates: destination, sources, guard and predicate writeback bypass.
    do_reset();
    clear_inputs(); issue_valid = 1; dest_pred_valid = 1; dest_pred_addr = 2'd2;
    #1;
    check("pred dest fire", issue_fire, 1'b1);
    @(negedge clk);
    clear_inputs(); issue_valid = 1; pred_src1_valid = 1; pred_src1_addr = 2'd2;
    #1;
    check("pred src1 stall", stall, 1'b1);
    @(negedge clk);
    clear_inputs(); issue_valid = 1; pred_src2_valid = 1; pred_src2_addr = 2'd2;
    wr_pred = 2'b10; wr_pred_addr = {2'd2, 2'd0};
    #1;
    check("pred bypass stall", stall, 1'b0);
    check("pred bypass fire", issue_fire, 1'b1);
    @(negedge clk);
    clear_inputs(); issue_valid = 1; dest_pred_valid = 1; dest_pred_addr = 2'd1;
    #1;
    check("pred idle", idle, 1'b1);
    @(negedge clk);
    clear_inputs(); issue_valid = 1; pred_reg_valid = 1; pred_reg_addr = 2'd1;
    #1;
    check("guard stall", stall, 1'b1);
    @(negedge clk);
    clear_inputs(); wr_pred = 2'b01; wr_pred_addr = {2'd0, 2'd1};
    @(negedge clk);
    clear_inputs(); issue_valid = 1; pred_reg_valid = 1; pred_reg_addr = 2'd1;
    #1;
    check("guard clear", stall, 1'b0);
    check("guard sb_error", sb_error, 1'b0);

    // Reset in the middle of a stream clears outputs without a clock edge.
    @(negedge clk);
    do_reset();
    issue_dest(1); func_unit = 3'd3;
    @(negedge clk);
    clear_inputs(); issue_valid = 1; reg_src1_valid = 1; reg_src1_addr = 4'd1; func_unit = 3'd3;
    #1;
    check("mid stall pre-reset", stall, 1'b1);
    check("mid idle pre-reset", idle, 1'b0);
    reset = 1'b1;
    #1;
    check("mid stall in reset", stall, 1'b0);
    check("mid fire in reset", issue_fire, 1'b1);
    check("mid idle in reset", idle, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post-reset fire", issue_fire, 1'b1);
    @(negedge clk);
    clear_inputs(); wr_reg = 2'b01; wr_reg_addr = 8'h01;
    @(negedge clk);
    clear_inputs();
    #1;
    check("stale wb sb_error", sb_error, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
